// File: rtl/mul_booth_seq.sv
// Radix-4 Booth sequential multiplier for RV32M MUL/MULH/MULHSU/MULHU on one reused CSA row.
// Latency: resp_valid in the 19th cycle after the accept cycle (1st cycle if either operand is zero).
// Backpressure: result held in DONE until resp_ready; req_ready only while IDLE.

module mul_booth_csa_row #(
   parameter int W = 35
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic [W-1:0] z_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] maj_o
);
   for (genvar k = 0; k < W; k++) begin : g_fa
      assign sum_o[k] = x_i[k] ^ y_i[k] ^ z_i[k];
      assign maj_o[k] = (x_i[k] & y_i[k]) | (x_i[k] & z_i[k]) | (y_i[k] & z_i[k]);
   end
endmodule

module mul_booth_seq #(
   parameter int XLEN  = 32,
   parameter int PPW   = XLEN + 3,
   parameter int NITER = (XLEN + 2) / 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            busy
);
   localparam int OPW = XLEN + 1;
   localparam int LOW = 2 * NITER;
   localparam int HIW = 2 * XLEN - LOW;
   localparam int CW  = $clog2(NITER);
   localparam logic [CW-1:0] LAST = CW'(NITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FINAL,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              hi_q, hi_d;
   logic [OPW-1:0]    mcand_q, mcand_d;
   logic [PPW-1:0]    mplr_q, mplr_d;
   logic [PPW-1:0]    sum_q, sum_d;
   logic [PPW-1:0]    cry_q, cry_d;
   logic              hold_q, hold_d;
   logic [LOW-1:0]    lo_q, lo_d;
   logic [XLEN-1:0]   resp_q, resp_d;

   // Operand extension to 33 bits: MULHU treats both unsigned, MULHSU only rs2.
   logic a_sgn, b_top;
   assign a_sgn = (req_op != 2'b11);
   assign b_top = !req_op[1] && req_b[XLEN-1];

   // Booth digit from the low triplet of the shifting multiplier {b, b[-1]=0}.
   logic [2:0]     trip;
   logic           pp_zero, pp_two, pp_neg;
   logic [PPW-1:0] a_ext, pp_mag, pp;
   assign trip    = mplr_q[2:0];
   assign pp_zero = (trip == 3'b000) || (trip == 3'b111);
   assign pp_two  = (trip == 3'b011) || (trip == 3'b100);
   assign pp_neg  = trip[2] && !pp_zero;
   assign a_ext   = {{(PPW-OPW){mcand_q[OPW-1]}}, mcand_q};
   assign pp_mag  = pp_zero ? '0 : (pp_two ? {a_ext[PPW-2:0], 1'b0} : a_ext);
   assign pp      = pp_neg ? ~pp_mag : pp_mag;

   logic [PPW-1:0] csa_sum, csa_maj, csa_cry;
   logic [2:0]     low_res;

   mul_booth_csa_row #(.W(PPW)) u_row (
      .x_i   (sum_q),
      .y_i   (cry_q),
      .z_i   (pp),
      .sum_o (csa_sum),
      .maj_o (csa_maj)
   );

   // cry_q is kept already weight-aligned; the vacated LSB carries the +1 of a negation.
   // Every row input fits in 34 signed bits, so dropping csa_maj's MSB loses nothing.
   assign csa_cry = {csa_maj[PPW-2:0], pp_neg};
   assign low_res = {1'b0, csa_sum[1:0]} + {1'b0, csa_cry[1:0]} + {2'b00, hold_q};

   logic [PPW-1:0]    fin;
   logic [2*XLEN-1:0] product;
   logic              unused_bits;
   assign fin         = sum_q + cry_q + {{(PPW-1){1'b0}}, hold_q};
   assign product     = {fin[HIW-1:0], lo_q};
   assign unused_bits = ^{fin[PPW-1:HIW], csa_maj[PPW-1]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      sum_d   = sum_q;
      cry_d   = cry_q;
      hold_d  = hold_q;
      lo_d    = lo_q;
      resp_d  = resp_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               hi_d    = (req_op != 2'b00);
               mcand_d = {a_sgn && req_a[XLEN-1], req_a};
               mplr_d  = {b_top, b_top, req_b, 1'b0};
               sum_d   = '0;
               cry_d   = '0;
               hold_d  = 1'b0;
               lo_d    = '0;
               cnt_d   = '0;
               if (req_a == '0 || req_b == '0) begin
                  state_d = S_DONE;
                  resp_d  = '0;
               end else begin
                  state_d = S_ITER;
               end
            end
         end
         S_ITER: begin
            sum_d   = {{2{csa_sum[PPW-1]}}, csa_sum[PPW-1:2]};
            cry_d   = {{2{csa_cry[PPW-1]}}, csa_cry[PPW-1:2]};
            hold_d  = low_res[2];
            lo_d    = {low_res[1:0], lo_q[LOW-1:2]};
            mplr_d  = {{2{mplr_q[PPW-1]}}, mplr_q[PPW-1:2]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_FINAL;
            end
         end
         S_FINAL: begin
            resp_d  = hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
            state_d = S_DONE;
         end
         S_DONE: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         hi_q    <= 1'b0;
         mcand_q <= '0;
         mplr_q  <= '0;
         sum_q   <= '0;
         cry_q   <= '0;
         hold_q  <= 1'b0;
         lo_q    <= '0;
         resp_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         sum_q   <= sum_d;
         cry_q   <= cry_d;
         hold_q  <= hold_d;
         lo_q    <= lo_d;
         resp_q  <= resp_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign resp_data  = resp_q;

endmodule

// File: doc/mul_booth_seq.md
Name: mul_booth_seq

Overview:
- Iterative radix-4 Booth multiply sequencer for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Owns and sequences a single 35-bit carry-save adder row (one full-adder slice per bit). The row is reused once per cycle to fold one Booth partial product into a carry-save accumulator.
- A final carry-propagate add produces the result.
- Sits between the EX stage issue logic and the writeback mux, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- PPW, 35, partial-product and CSA row width (XLEN+3).
- NITER, 17, number of Booth iterations ((XLEN+2)/2).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  multiply request valid
- req_ready  output  1  sequencer can accept a request
- req_op  input  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU
- req_a  input  32  rs1 (multiplicand)
- req_b  input  32  rs2 (multiplier)
- flush  input  1  kill any in-flight operation
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer takes result
- resp_data  output  32  low word (MUL) or high word (MULH*)
- busy  output  1  state != IDLE

Behaviour:
- Reset: clk and rst_n are the only clock/reset. Reset is synchronous and active-low, sampled on the rising edge of clk.
  - Reset state is IDLE.
  - Reset values: req_ready=1, resp_valid=0, resp_data=0, busy=0, all accumulators 0.
  - Reset mid-operation discards the operation.
- States: IDLE, ITER, FINAL, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&!flush, latch the operands and go to ITER with the iteration counter at 0.
  - Operand extension to 33 bits: a is sign-extended for MUL/MULH/MULHSU; b is sign-extended for MUL/MULH. Otherwise zero-extended.
  - Zero shortcut: if req_a==0 or req_b==0, go directly to DONE with resp_data=0.
- ITER, one cycle per iteration, counter 0..16:
  - Booth-encode the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0, into one of 0, ±A, ±2A, sign-extended to PPW.
  - Negation is one's complement, with the +1 injected into the carry vector's vacated LSB.
  - Feed the CSA row with (sum_acc, carry_acc<<1, pp).
  - Shift right by 2 arithmetically. The low 2 bits of sum+carry are resolved by a 2-bit adder whose carry-out is kept in a 1-bit register. The resolved bits shift into the low product register.
  - After counter==16, go to FINAL.
- FINAL:
  - One 35-bit carry-propagate add of the sum and carry vectors plus the held bit.
  - Form the 64-bit product.
  - Select resp_data: low 32 bits for op 00, high 32 bits otherwise.
  - Go to DONE.
- DONE:
  - resp_valid=1; resp_data is held stable until the handshake.
  - On resp_ready, go to IDLE.
  - No new request is accepted in the DONE cycle (req_ready=0 outside IDLE).
- Latency:
  - Non-zero operands: resp_valid rises 19 cycles after the accepting edge (17 ITER + 1 FINAL + 1 to DONE).
  - Zero shortcut: resp_valid rises 1 cycle after the accepting edge.
- Flush: synchronous; forces IDLE from any state on the next edge and drops resp_valid.
  - A flush in IDLE with req_valid blocks acceptance (flush has priority).
  - A flush in DONE with resp_ready still discards the result; the consumer must qualify with its own flush.
- Backpressure: with resp_ready held low, the sequencer stays in DONE indefinitely with outputs stable.
- Arithmetic: the result equals the exact two's-complement/unsigned product per the RV32M definition. Overflow bits above 64 are discarded. Boundary cases needing explicit coverage: -2^31 × -2^31, and MULHSU with a negative rs1.

Test Plan:
- Reset mid-ITER (rst_n=0 for 1 cycle at iteration 5) -> next cycle busy=0, req_ready=1, resp_valid=0.
- MUL a=7, b=6 -> resp_valid exactly 19 cycles after accept, resp_data=0x0000002A. Then MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_data=0xFFFFFFFE.
- MULH a=0x80000000, b=0x80000000 -> resp_data=0x40000000. MUL of the same operands -> 0x00000000. MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> resp_data=0xFFFFFFFF.
- Zero shortcut: MULH a=0, b=0x12345678 -> resp_valid 1 cycle after accept, resp_data=0.
- Backpressure: MUL a=3, b=5 with resp_ready=0 for 10 cycles -> resp_valid and resp_data=0x0000000F held stable. req_ready stays 0 until the cycle after resp_ready=1.
- Flush at iteration 8 with req_valid=1 in the same cycle -> no resp_valid ever for that op. IDLE next cycle. The new request is accepted only the cycle after flush deasserts.
